// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-port RAM to dcache (priority) or icache.
// The grant is the registered FSM state; an age counter lets icache win once
// it has lost STARVE_MAX consecutive grant decisions to dcache.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [7:0]  err_cnt
);
  localparam int unsigned AGE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [7:0]       err_q, err_d;
  logic             dreq, starve;

  assign dreq    = dREN | dWEN;
  assign starve  = (age_q >= AGE_MAX);
  assign err_cnt = err_q;

  // State, age and error counter registers; async reset clears the grant so
  // the RAM strobes (decoded from state) drop immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      age_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, RAM muxing and response decode. A dropped request aborts the
  // serve silently: strobes fall this cycle, no wait pulse, no counter change.
  always_comb begin
    state_d  = state_q;
    age_d    = age_q;
    err_d    = err_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IDLE: begin
        if (dreq && !(iREN && starve)) begin
          state_d = DSERV;
          if (iREN && !starve) age_d = age_q + 1'b1;
        end else if (iREN) begin
          state_d = ISERV;
          age_d   = '0;
        end
      end
      DSERV: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RS_ACCESS) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RS_ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after the rising edge,
// outputs are checked mid-cycle against hand-computed values.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #3;
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iload", iload, 0);
    chk("rst_err", err_cnt, 0);
    cyc();
    nRST = 1'b1;
    cyc();

    // 1: icache read, two BUSY then ACCESS
    iREN = 1; iaddr = 32'h40; #1;
    chk("t1_idle_ren", ramREN, 0);
    cyc();                          // ISERV
    ramstate = BUSY; ramload = 32'h1234_5678; #1;
    chk("t1_busy_ren", ramREN, 1);
    chk("t1_busy_addr", ramaddr, 32'h40);
    chk("t1_busy_iwait", iwait, 1);
    chk("t1_busy_iload", iload, 0);
    cyc();
    chk("t1_busy2_iwait", iwait, 1);
    ramstate = ACCESS; #1;
    chk("t1_acc_iwait", iwait, 0);
    chk("t1_acc_iload", iload, 32'h1234_5678);
    chk("t1_acc_wen", ramWEN, 0);
    chk("t1_acc_dwait", dwait, 1);
    iREN = 0;
    cyc();                          // IDLE
    ramstate = FREE; #1;
    chk("t1_after_iwait", iwait, 1);

    // 2: dcache write and icache read together; write goes first
    dWEN = 1; daddr = 32'h3100; dstore = 32'hCAFE; iREN = 1; iaddr = 32'h80;
    cyc();                          // DSERV (age 0->1)
    chk("t2_wen", ramWEN, 1);
    chk("t2_ren", ramREN, 0);
    chk("t2_addr", ramaddr, 32'h3100);
    chk("t2_store", ramstore, 32'hCAFE);
    ramstate = ACCESS; #1;
    chk("t2_dwait", dwait, 0);
    chk("t2_iwait", iwait, 1);
    cyc();                          // IDLE
    dWEN = 0; ramstate = FREE;
    cyc();                          // ISERV (age cleared)
    chk("t2_i_addr", ramaddr, 32'h80);
    chk("t2_i_ren", ramREN, 1);
    ramstate = ACCESS; ramload = 32'h0BAD_F00D; #1;
    chk("t2_i_iwait", iwait, 0);
    chk("t2_i_iload", iload, 32'h0BAD_F00D);
    iREN = 0;
    cyc();
    ramstate = FREE;

    // 4: dREN+dWEN -> write wins
    dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h77;
    cyc();                          // DSERV
    chk("t4_wen", ramWEN, 1);
    chk("t4_ren", ramREN, 0);
    ramstate = ACCESS; #1;
    chk("t4_dload_on_write", dwait, 0);
    dREN = 0; dWEN = 0;
    cyc();
    ramstate = FREE;

    // 3: sustained dcache reads with icache waiting; 5th grant is icache
    dREN = 1; daddr = 32'h200; iREN = 1; iaddr = 32'h44;
    for (int g = 1; g <= 6; g++) begin
      cyc();                        // serve state
      ramstate = ACCESS; ramload = 32'h100 + g; #1;
      chk($sformatf("t3_g%0d_addr", g), ramaddr, (g == 5) ? 32'h44 : 32'h200);
      chk($sformatf("t3_g%0d_iwait", g), iwait, (g == 5) ? 0 : 1);
      chk($sformatf("t3_g%0d_dwait", g), dwait, (g == 5) ? 1 : 0);
      cyc();                        // IDLE
      ramstate = FREE;
    end
    dREN = 0; iREN = 0;
    cyc();

    // 5: ERROR during DSERV, then retry
    dREN = 1; daddr = 32'h300;
    cyc();                          // DSERV
    ramstate = ERROR; ramload = 32'hDEAD; #1;
    chk("t5_err_dwait", dwait, 1);
    chk("t5_err_dload", dload, 0);
    chk("t5_err_cnt_before", err_cnt, 0);
    cyc();                          // IDLE
    ramstate = FREE; #1;
    chk("t5_err_cnt_after", err_cnt, 1);
    cyc();                          // DSERV retry
    chk("t5_retry_ren", ramREN, 1);
    chk("t5_retry_addr", ramaddr, 32'h300);
    ramstate = ACCESS; ramload = 32'hBEEF; #1;
    chk("t5_retry_dwait", dwait, 0);
    chk("t5_retry_dload", dload, 32'hBEEF);
    dREN = 0;
    cyc();
    ramstate = FREE;

    // 6: abort mid-BUSY, then async reset mid ISERV
    dREN = 1; daddr = 32'h600;
    cyc();                          // DSERV
    ramstate = BUSY; #1;
    chk("t6_busy_ren", ramREN, 1);
    dREN = 0; #1;
    chk("t6_abort_ren", ramREN, 0);
    chk("t6_abort_dwait", dwait, 1);
    cyc();                          // IDLE
    chk("t6_abort_err", err_cnt, 1);
    iREN = 1; iaddr = 32'h900;
    cyc();                          // ISERV
    chk("t6_iserv_ren", ramREN, 1);
    #2; nRST = 1'b0; #1;
    chk("t6_rst_ren", ramREN, 0);
    chk("t6_rst_addr", ramaddr, 0);
    chk("t6_rst_iwait", iwait, 1);
    chk("t6_rst_dwait", dwait, 1);
    chk("t6_rst_err", err_cnt, 0);
    iREN = 0;
    cyc();
    nRST = 1'b1;
    cyc();
    chk("t6_post_ren", ramREN, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
